timer_bcd_core: RTL and testbench

TIMER_BCD_CORE -- requirements
Module: timer_bcd_core

---
 rtl/timer_bcd_core.sv | 148 ++++++++++++++
 tb/tb_timer_bcd_core.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/timer_bcd_core.sv
// MM:SS stopwatch core: prescaled one-second tick, BCD cascade, IDLE/RUN/PAUSE FSM.
// Optional display hold (lap) is compiled in with macro TIMER_LAP_EN.
module timer_bcd_core #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] data,
    output logic        running,
    output logic        wrap,
    output logic        lap_active
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [26:0] PRESC_MAX = 27'(TICK_DIV - 1);

    state_t      state_r;
    state_t      state_next_s;
    logic [26:0] presc_r;
    logic [26:0] presc_next_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_next_s;
    logic [15:0] data_r;
    logic [15:0] data_next_s;
    logic        running_r;
    logic        wrap_r;
    logic        wrap_next_s;
    logic        tick_s;

    // Out-of-range digits are treated as carry so the counter self-corrects.
    function automatic logic [15:0] bcd_inc(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (d[3:0] < 4'd9) begin
            r[3:0] = d[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (d[7:4] < 4'd5) begin
                r[7:4] = d[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (d[11:8] < 4'd9) begin
                    r[11:8] = d[11:8] + 4'd1;
                end else begin
                    r[11:8] = 4'd0;
                    if (d[15:12] < 4'd5) begin
                        r[15:12] = d[15:12] + 4'd1;
                    end else begin
                        r[15:12] = 4'd0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Next-state, prescaler and digit logic; clear dominates start_stop.
    always_comb begin
        state_next_s = state_r;
        tick_s       = (state_r == ST_RUN) && (presc_r == PRESC_MAX);
        case (state_r)
            ST_IDLE:  if (start_stop) state_next_s = ST_RUN;   else state_next_s = ST_IDLE;
            ST_RUN:   if (start_stop) state_next_s = ST_PAUSE; else state_next_s = ST_RUN;
            ST_PAUSE: if (start_stop) state_next_s = ST_RUN;   else state_next_s = ST_PAUSE;
            default:  state_next_s = ST_IDLE;
        endcase
        if (clear) begin
            state_next_s = ST_IDLE;
            presc_next_s = 27'd0;
            cnt_next_s   = 16'h0000;
            wrap_next_s  = 1'b0;
        end else begin
            if (state_r == ST_RUN) begin
                presc_next_s = tick_s ? 27'd0 : presc_r + 27'd1;
            end else begin
                presc_next_s = presc_r;
            end
            cnt_next_s  = tick_s ? bcd_inc(cnt_r) : cnt_r;
            wrap_next_s = tick_s && (cnt_r == 16'h5959);
        end
    end

`ifdef TIMER_LAP_EN
    logic hold_r;
    logic hold_next_s;

    // Lap toggles the hold outside IDLE; the edge that sets it captures the fresh digits.
    always_comb begin
        hold_next_s = hold_r;
        if (clear) begin
            hold_next_s = 1'b0;
        end else if (lap && (state_r != ST_IDLE)) begin
            hold_next_s = ~hold_r;
        end else begin
            hold_next_s = hold_r;
        end
        data_next_s = (hold_r && hold_next_s) ? data_r : cnt_next_s;
    end

    // Hold flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r <= 1'b0;
        end else begin
            hold_r <= hold_next_s;
        end
    end

    assign lap_active = hold_r;
`else
    logic unused_lap_s;
    assign unused_lap_s = lap;
    assign data_next_s  = cnt_next_s;
    assign lap_active   = 1'b0;
`endif

    // State, prescaler, digits and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            presc_r   <= 27'd0;
            cnt_r     <= 16'h0000;
            data_r    <= 16'h0000;
            running_r <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            presc_r   <= presc_next_s;
            cnt_r     <= cnt_next_s;
            data_r    <= data_next_s;
            running_r <= (state_next_s == ST_RUN);
            wrap_r    <= wrap_next_s;
        end
    end

    assign data    = data_r;
    assign running = running_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_timer_bcd_core.sv
// Self-checking bench for timer_bcd_core (TICK_DIV=4): directed scenarios with
// literal expectations plus randomized pulses checked against a seconds-based model.
module tb_timer_bcd_core;

    localparam int TD = 4;
`ifdef TIMER_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] data;
    logic        running;
    logic        wrap;
    logic        lap_active;

    timer_bcd_core #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
        .data(data), .running(running), .wrap(wrap), .lap_active(lap_active)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: 0=idle 1=run 2=pause; elapsed seconds; sub-second phase; hold state.
    int m_mode  = 0;
    int m_sec   = 0;
    int m_phase = 0;
    int m_hold  = 0;
    int m_froz  = 0;
    int m_wrap  = 0;
    bit m_valid = 1'b0;

    function automatic logic [15:0] to_bcd(input int sec);
        int mm, ss;
        mm = sec / 60;
        ss = sec % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit ss, input bit clr, input bit lp);
        bit tick;
        if (r || clr) begin
            m_mode = 0; m_sec = 0; m_phase = 0; m_hold = 0; m_froz = 0; m_wrap = 0;
        end else begin
            tick   = (m_mode == 1) && (m_phase == TD - 1);
            m_wrap = (tick && m_sec == 3599) ? 1 : 0;
            if (m_mode == 1) m_phase = tick ? 0 : m_phase + 1;
            if (tick) m_sec = (m_sec + 1) % 3600;
            if (LAP_EN && lp && m_mode != 0) begin
                m_hold = (m_hold != 0) ? 0 : 1;
                if (m_hold != 0) m_froz = m_sec;
            end
            if (ss) m_mode = (m_mode == 1) ? 2 : 1;
        end
    endtask

    task automatic step(input bit r, input bit ss, input bit clr, input bit lp);
        rst = r; start_stop = ss; clear = clr; lap = lp;
        @(posedge clk);
        model_edge(r, ss, clr, lp);
        m_valid = 1'b1;
        #1;
        rst = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("data",       data,               (m_hold != 0) ? to_bcd(m_froz) : to_bcd(m_sec));
            chk("running",    {15'd0, running},    {15'd0, m_mode == 1});
            chk("wrap",       {15'd0, wrap},       {15'd0, m_wrap != 0});
            chk("lap_active", {15'd0, lap_active}, {15'd0, m_hold != 0});
        end
    end

    initial begin
        // Reset for two cycles.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_data", data, 16'h0000);
        chk("rst_outs", {13'd0, running, wrap, lap_active}, 16'h0000);

        // First tick lands TICK_DIV edges after start.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("first_pre", data, 16'h0000);
        idle(1);
        chk("first_tick", data, 16'h0001);
        chk("first_run", {15'd0, running}, 16'h0001);

        idle(39 * TD);
        chk("t40", data, 16'h0040);
        idle(20 * TD);
        chk("t100", data, 16'h0100);

        // Pause with prescaler at 2, resume, next tick two edges later.
        idle(1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(10);
        chk("pause_data", data, 16'h0100);
        chk("pause_run", {15'd0, running}, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("resume_pre", data, 16'h0100);
        idle(1);
        chk("resume_tick", data, 16'h0101);

        // clear wins over start_stop.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("clr_data", data, 16'h0000);
        chk("clr_run", {15'd0, running}, 16'h0000);

        // Reset mid-second.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(TD + 2);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("midrst", {data[12:0], running, wrap, lap_active}, 16'h0000);

        // Lap hold.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(12 * TD);
        chk("lap_pre", data, 16'h0012);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(5 * TD);
        chk("lap_hold", data, LAP_EN ? 16'h0012 : 16'h0017);
        chk("lap_act", {15'd0, lap_active}, {15'd0, LAP_EN});
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lap_rel", data, 16'h0017);
        chk("lap_off", {15'd0, lap_active}, 16'h0000);

        // Rollover 59:59 -> 00:00 with a single-cycle wrap.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3599 * TD);
        chk("pre_wrap", data, 16'h5959);
        chk("pre_wrap_flag", {15'd0, wrap}, 16'h0000);
        idle(TD);
        chk("wrap_data", data, 16'h0000);
        chk("wrap_flag", {15'd0, wrap}, 16'h0001);
        idle(1);
        chk("wrap_once", {15'd0, wrap}, 16'h0000);
        chk("wrap_run", {15'd0, running}, 16'h0001);

        // Randomized pulses checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 79) == 0, $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
